// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg
// Shared definitions for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the top-level mode input
//   CNT_W                : width of the optional transfer counter
//   MAX_CH               : widest channel vector next_rr_grant handles
//   next_rr_grant()      : one-hot round-robin grant search
package rr_stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   CNT_W      = 16;
  localparam int   MAX_CH     = 16;

  // Searches last+1, last+2, ... modulo num_ch and returns a one-hot grant
  // for the first requesting channel; all zeros when nothing requests.
  function automatic logic [MAX_CH-1:0] next_rr_grant(
    input logic [MAX_CH-1:0] valid,
    input logic [3:0]        last,
    input int                num_ch
  );
    logic [MAX_CH-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= num_ch && !found) begin
        idx = (int'(last) + k) % num_ch;
        if (valid[idx[3:0]]) begin
          g[idx[3:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter that owns the "last granted" pointer.
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-channel request vector
//   ptr_advance : a transfer happened this cycle on channel grant_idx
//   grant_idx   : index of the channel that transferred
//   grant       : one-hot round-robin grant (combinational)
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              ptr_advance,
  input  logic [SEL_W-1:0]  grant_idx,
  output logic [NUM_CH-1:0] grant
);

  logic [SEL_W-1:0]  last;
  logic [MAX_CH-1:0] g_full;

  // Reset to the top channel so channel 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SEL_W'(NUM_CH - 1);
    end else if (ptr_advance) begin
      last <= grant_idx;
    end
  end

  always_comb begin
    g_full = next_rr_grant(MAX_CH'(req), 4'(last), NUM_CH);
    grant  = g_full[NUM_CH-1:0];
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux
// N-channel valid/ready stream multiplexer with a registered output stage
// and either software-fixed or round-robin channel selection.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : packed channel data, channel i at [i*DATA_W +: DATA_W]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, at most one bit high
//   mode       : 0 = fixed select (sel), 1 = round-robin
//   sel        : channel index used in fixed mode
//   out_data   : registered data of the accepted beat
//   out_ch     : channel index that supplied out_data
//   out_valid  : output register holds a beat
//   out_ready  : downstream accepts the beat
//   xfer_cnt   : saturating count of accepted transfers
//                (only when RR_STREAM_MUX_CNT_EN is defined)
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef RR_STREAM_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]         xfer_cnt
`endif
);

  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] fix_grant;
  logic [NUM_CH-1:0] grant_p0;
  logic              load_en_p0;
  logic              xfer_p0;
  logic [SEL_W-1:0]  xfer_idx_p0;
  logic [DATA_W-1:0] xfer_data_p0;

  logic [DATA_W-1:0] data_p1;
  logic [SEL_W-1:0]  ch_p1;
  logic              vld_p1;

  // Stage p0: grant selection and input handshake
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (in_valid),
    .ptr_advance (xfer_p0),
    .grant_idx   (xfer_idx_p0),
    .grant       (rr_grant)
  );

  always_comb begin
    fix_grant = '0;
    // An out-of-range select grants nothing.
    if (int'(sel) < NUM_CH) fix_grant[sel] = in_valid[sel];
  end

  always_comb begin
    grant_p0   = (mode == MODE_RR) ? rr_grant : fix_grant;
    load_en_p0 = !vld_p1 || out_ready;
    in_ready   = grant_p0 & {NUM_CH{load_en_p0 && !rst}};
    xfer_p0    = |(in_valid & in_ready);
  end

  always_comb begin
    xfer_idx_p0  = '0;
    xfer_data_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_p0[i]) begin
        xfer_idx_p0  = SEL_W'(i);
        xfer_data_p0 = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: output register; a drain with no refill keeps data and channel
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= xfer_data_p0;
      ch_p1   <= xfer_idx_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_valid = vld_p1;

`ifdef RR_STREAM_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (xfer_p0) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign xfer_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef RR_STREAM_MUX_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b1;
  beat_t exp_q[$];

  rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_STREAM_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle and let combinational outputs settle.
  task automatic drive(input logic [3:0] v, input logic m, input logic [1:0] s, input logic ordy);
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] c);
    beat_t b;
    b.data = d;
    b.ch   = c;
    exp_q.push_back(b);
  endtask

  // Monitor: every beat the consumer takes must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      beat_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual data=%0h ch=%0d required none", out_data, out_ch);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_ch !== e.ch) begin
          failures++;
          $display("FAIL beat actual data=%0h ch=%0d required data=%0h ch=%0d",
                   out_data, out_ch, e.data, e.ch);
        end
      end
    end
  end

  logic [7:0] rr_data [4];
  logic [1:0] rr_ch   [6];
  logic [3:0] sw_rdy  [4];

  initial begin
    rr_data = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    rr_ch   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sw_rdy  = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};

    // Reset with every channel valid: nothing may be accepted.
    rst     = 1'b1;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    drive(4'hF, 1'b0, 2'd0, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    chk("rst_in_ready2", 32'(in_ready), 32'h0);
    rst = 1'b0;
    drive(4'h0, 1'b0, 2'd0, 1'b1);
    tick();

    // Fixed mode, sel=2: only channel 2 ever gets ready.
    for (int k = 0; k < 3; k++) begin
      push(8'hA5, 2'd2);
      drive(4'hF, 1'b0, 2'd2, 1'b1);
      chk("fixed_in_ready", 32'(in_ready), 32'b0100);
      tick();
      chk("fixed_out_data", 32'(out_data), 32'hA5);
      chk("fixed_out_ch", 32'(out_ch), 32'd2);
    end
    drive(4'h0, 1'b0, 2'd2, 1'b1);
    tick();

    // Re-reset so the pointer restarts at channel 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // RR fairness with all channels valid.
    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int k = 0; k < 6; k++) begin
      push(rr_data[rr_ch[k]], rr_ch[k]);
      drive(4'hF, 1'b1, 2'd0, 1'b1);
      chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << rr_ch[k]));
      tick();
    end

    // RR skip and wrap: pointer sits at 1, so 3 wins first, then 0.
    for (int k = 0; k < 4; k++) begin
      push((k % 2 == 0) ? 8'hD3 : 8'hA0, (k % 2 == 0) ? 2'd3 : 2'd0);
      drive(4'b1001, 1'b1, 2'd0, 1'b1);
      chk("wrap_in_ready", 32'(in_ready), 32'(sw_rdy[k]));
      tick();
    end
    drive(4'h0, 1'b1, 2'd0, 1'b1);
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // Fixed mode with the selected channel idle grants nothing.
    drive(4'b1101, 1'b0, 2'd1, 1'b1);
    chk("fixed_idle_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("fixed_idle_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: pointer at 0, so channel 1 loads, then stalls.
    push(8'hB1, 2'd1);
    drive(4'hF, 1'b1, 2'd0, 1'b1);
    chk("bp_first_in_ready", 32'(in_ready), 32'b0010);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 1'b1, 2'd0, 1'b0);
      chk("bp_stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_stall_out_data", 32'(out_data), 32'hB1);
      chk("bp_stall_out_valid", 32'(out_valid), 32'h1);
    end
    push(8'hC2, 2'd2);
    drive(4'hF, 1'b1, 2'd0, 1'b1);
    chk("bp_release_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("bp_nobubble_valid", 32'(out_valid), 32'h1);
    chk("bp_nobubble_ch", 32'(out_ch), 32'd2);
    drive(4'h0, 1'b1, 2'd0, 1'b1);
    tick();
    chk("bp_drain_valid", 32'(out_valid), 32'h0);
    chk("bp_drain_hold_data", 32'(out_data), 32'hC2);
    chk("bp_drain_hold_ch", 32'(out_ch), 32'd2);

`ifdef RR_STREAM_MUX_CNT_EN
    // Counter saturation and reset clear.
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_reset", 32'(xfer_cnt), 32'h0);
    drive(4'hF, 1'b1, 2'd0, 1'b1);
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_saturate", 32'(xfer_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_hold", 32'(xfer_cnt), 32'hFFFF);
    rst = 1'b1;
    #1;
    chk("cnt_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("cnt_rst_value", 32'(xfer_cnt), 32'h0);
    chk("cnt_rst_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    drive(4'h0, 1'b1, 2'd0, 1'b1);
    tick();
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor of the combinational 4:1 mux: N channels of DATA_W-bit data.
- Per-channel valid/ready handshakes and a registered output stage.
- Two selection modes:
  - fixed: a software-driven select picks the channel;
  - round-robin: fair arbitration across requesting channels.
- Sits between several producer blocks and a single downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel (1..64).
- SEL_W, $clog2(NUM_CH), select/channel-index width. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  DATA_W  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
  - in_ready all 0 during the reset cycle.
- Output stage:
  - load_en = !out_valid | out_ready (same-cycle refill allowed; full throughput of 1 beat/cycle).
- Grant (combinational, one-hot, computed every cycle):
  - Fixed mode: grant[sel]=in_valid[sel]. If sel>=NUM_CH, no grant.
  - RR mode: first i with in_valid[i]=1, searching last+1, last+2, … modulo NUM_CH. No valid inputs means no grant.
- Handshakes:
  - in_ready[i] = grant[i] & load_en & !rst.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
  - Producers must hold in_valid and in_data stable until accepted. in_ready may depend combinationally on in_valid.
- On transfer: out_data <= channel i data, out_ch <= i, out_valid <= 1, last <= i.
- Drain: if out_ready=1 and there is no transfer, out_valid <= 0; out_data and out_ch hold their values.
- Stall: out_valid=1 and out_ready=0 means all in_ready=0 and the output register holds.
- Latency: input accepted at edge N appears at the output immediately after edge N (one register stage).
- Pointer behaviour:
  - last updates only on a transfer, in either mode.
  - Switching modes does not reset last; the new mode applies from the next cycle's grant.
- sel and mode are sampled every cycle. Changes during a stall take effect at the next load_en cycle.
- Reset mid-operation: any held beat is discarded (out_valid=0) and no in_ready is asserted.

Optional Feature:
- Macro: RR_STREAM_MUX_CNT_EN.
- Defined:
  - Adds output port xfer_cnt (16 bits): total accepted input transfers since reset.
  - Increments by 1 per transfer and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package rr_stream_mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function next_rr_grant(valid, last), returning a one-hot grant.
  - Localparam CNT_W=16.
- One sub-module rr_arbiter (parameter NUM_CH):
  - Inputs: req, ptr_advance, granted index.
  - Outputs: one-hot grant.
  - Owns the last pointer.
- Top level owns the mode mux, output register, handshakes and the optional counter.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0.
- Fixed mode, NUM_CH=4, DATA_W=8: sel=2, in_data ch2=8'hA5, all valid, out_ready=1 → after 1 clk out_data=8'hA5, out_ch=2; only in_ready[2] is ever high.
- RR fairness: all 4 valid and constant, out_ready=1 → out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
- RR skip and wrap: in_valid=4'b1001 → out_ch alternates 0,3,0,3.
- Backpressure: out_ready=0 for 3 cycles while a beat is held → out_data stable, in_ready=0. When out_ready rises, the next beat loads on the same edge the old one drains (no bubble).
- With RR_STREAM_MUX_CNT_EN: 70000 transfers → xfer_cnt=16'hFFFF and stays there. Reset mid-run → xfer_cnt=0 and out_valid=0.
